si_dac_multi: RTL and testbench
===============================

# si_dac_multi

Parametrised multi-channel serial-input DAC, the next generation of our single-channel 12-bit serial DAC bench model. Receives MSB-first serial frames carrying a command, channel address and WIDTH-bit code, holds a double-buffered (input/DAC) register pair per channel, and drives one real-valued analog output per channel. Adds addressing, deferred and global update (LDAC), per-channel power-down and frame-error detection. Used as a behavioural DAC in the sine-wave project benches.

## Interface

- WIDTH, 12, data bits per channel (≥ 2)
- CH, 4, number of channels (≥ 1)
- ADDR_W, $clog2(CH) but minimum 1, address field width (derived, not overridden)
- VREF, 1.0, real full-scale reference in volts

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- soc  input  1  start-of-frame pulse, one cycle
- SI  input  1  serial data, MSB first
- SI_en  input  1  bit-valid qualifier; SI is sampled only when high
- ldac  input  1  synchronous global update strobe
- A_out  output  real [CH]  analog output per channel
- busy  output  1  high in SHIFT and LATCH
- done  output  1  one-cycle pulse when a valid frame is executed
- frame_err  output  1  sticky error flag, cleared by next accepted soc

## Operation

- Frame length L = 2 + ADDR_W + WIDTH bits: cmd[1:0], addr[ADDR_W-1:0], code[WIDTH-1:0], MSB first.
- Commands: 00 write input reg only; 01 write input reg and update that channel's DAC reg; 10 update all DAC regs from input regs (addr/code ignored); 11 power down addressed channel (code ignored).
- FSM states IDLE, SHIFT, LATCH.
  - IDLE: soc → SHIFT, bit counter = 0, frame_err cleared.
  - SHIFT: each edge with SI_en=1 shifts SI in, counter++. SI_en=0 stalls (count and shift reg held). On L-th bit → LATCH.
  - LATCH: one cycle; command executed on the edge leaving it; → IDLE, or → SHIFT if soc is high in LATCH (new frame, previous still executed).
- soc during SHIFT: current frame aborted (nothing written), frame_err=1, restart counting from 0.
- addr ≥ CH for cmd 00/01/11: frame discarded, frame_err=1, done not pulsed. cmd 10 always valid.
- ldac=1 on an edge: every DAC reg ← its input reg. If a frame commits on the same edge, ldac uses the newly written input value.
- Power-down: channel output forced to 0.0; DAC reg retained. Cleared for a channel by cmd 01 to it, by cmd 10, or by ldac. Reset clears all power-down.
- A_out[i] = powered_down[i] ? 0.0 : VREF * dac_reg[i] / 2**WIDTH (continuous from registered state). Full-scale code gives VREF·(2**WIDTH−1)/2**WIDTH.
- SI/SI_en in IDLE ignored.

## Timing

- Reset (async, rst_n=0): state IDLE, all input/DAC regs 0, power-down clear, A_out[i]=0.0, busy=0, done=0, frame_err=0. Reset mid-frame discards the frame.
- Last bit sampled at edge E → LATCH; execution and done=1 after edge E+1; A_out updated after E+1; done low after E+2 unless another frame completes.
- Minimum frame time L+1 cycles with SI_en continuously high; back-to-back frames possible with soc asserted in LATCH.
- ldac effect visible on A_out after the edge it is sampled on (1-cycle latency), independent of FSM state.
- busy rises after the soc edge, falls after edge E+1.

## Test plan

- Reset then cmd 01, addr 2, code 0x800, SI_en held high (16 bits) -> done pulse at edge 17 after soc, A_out[2]=0.5, other channels 0.0.
- cmd 00 writes ch0=0xFFF, ch1=0x400; then ldac pulse -> A_out unchanged until ldac edge, then A_out[0]=0.999756, A_out[1]=0.25.
- cmd 01 ch3=0x200, then cmd 11 ch3 -> A_out[3]=0.0; then cmd 10 -> A_out[3]=0.125 restored.
- SI_en toggled 0/1 every cycle during frame (cmd 01, ch1, 0xC00) -> correct result, done after 32 enabled-stall cycles +1, A_out[1]=0.75.
- soc reasserted after 7 bits -> frame_err=1, no register change; following clean frame clears frame_err and executes.
- CH=3 parameter build, frame addr 3 -> frame_err=1, no done; rst_n low mid-frame -> all outputs to reset values immediately.

Source files
------------

// File: rtl/si_dac_multi.sv
// Multi-channel serial-input DAC model: MSB-first frames {cmd, addr, code}, double-buffered
// input/DAC registers per channel, global LDAC update, per-channel power-down.
//   state | meaning
//   IDLE  | waiting for soc; SI/SI_en ignored
//   SHIFT | collecting L frame bits, stalled while SI_en is low
//   LATCH | full frame held; command executes on the edge leaving this state
module si_dac_multi #(
   parameter int  WIDTH = 12,
   parameter int  CH    = 4,
   parameter real VREF  = 1.0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic soc,
   input  logic SI,
   input  logic SI_en,
   input  logic ldac,
   output real  A_out [CH],
   output logic busy,
   output logic done,
   output logic frame_err
);

   localparam int  ADDR_W = (CH > 1) ? $clog2(CH) : 1;
   localparam int  L      = 2 + ADDR_W + WIDTH;
   localparam int  CNT_W  = $clog2(L + 1);
   localparam real LSB    = VREF / (2.0 ** WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [L-1:0]       sr, sr_nxt;
   logic               done_nxt, err_nxt;
   logic [CH-1:0]      pd, pd_nxt;
   logic [WIDTH-1:0]   in_reg [CH];
   logic [WIDTH-1:0]   in_nxt [CH];
   logic [WIDTH-1:0]   dac_reg [CH];
   logic [WIDTH-1:0]   dac_nxt [CH];

   logic [1:0]         cmd;
   logic [ADDR_W-1:0]  addr;
   logic [WIDTH-1:0]   code;
   logic               frame_ok;

   assign cmd      = sr[L-1 -: 2];
   assign addr     = sr[WIDTH +: ADDR_W];
   assign code     = sr[WIDTH-1:0];
   // Zero-extend so the range check stays meaningful when CH is a power of two.
   assign frame_ok = (cmd == 2'b10) || ({1'b0, addr} < (ADDR_W + 1)'(CH));
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         pd        <= '0;
         for (int i = 0; i < CH; i++) begin
            in_reg[i]  <= '0;
            dac_reg[i] <= '0;
         end
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         sr        <= sr_nxt;
         done      <= done_nxt;
         frame_err <= err_nxt;
         pd        <= pd_nxt;
         in_reg    <= in_nxt;
         dac_reg   <= dac_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sr_nxt    = sr;
      done_nxt  = 1'b0;
      err_nxt   = frame_err;
      pd_nxt    = pd;
      in_nxt    = in_reg;
      dac_nxt   = dac_reg;

      case (state)
         IDLE: begin
            if (soc) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
            end
         end
         SHIFT: begin
            if (soc) begin
               cnt_nxt = '0;
               err_nxt = 1'b1;
            end else if (SI_en) begin
               sr_nxt  = {sr[L-2:0], SI};
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(L - 1)) state_nxt = LATCH;
            end
         end
         LATCH: begin
            if (soc) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
            end else begin
               state_nxt = IDLE;
            end
            // A bad address in the executing frame outranks the clear from a back-to-back soc.
            if (!frame_ok) begin
               err_nxt = 1'b1;
            end else begin
               done_nxt = 1'b1;
               for (int i = 0; i < CH; i++) begin
                  if (ADDR_W'(i) == addr) begin
                     case (cmd)
                        2'b00: in_nxt[i] = code;
                        2'b01: begin
                           in_nxt[i]  = code;
                           dac_nxt[i] = code;
                           pd_nxt[i]  = 1'b0;
                        end
                        2'b11: pd_nxt[i] = 1'b1;
                        default: ;
                     endcase
                  end
               end
               if (cmd == 2'b10) begin
                  for (int i = 0; i < CH; i++) dac_nxt[i] = in_reg[i];
                  pd_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (ldac) begin
         for (int i = 0; i < CH; i++) dac_nxt[i] = in_nxt[i];
         pd_nxt = '0;
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         A_out[i] = pd[i] ? 0.0 : LSB * real'(dac_reg[i]);
      end
   end

endmodule

// File: tb/tb_si_dac_multi.sv
// Directed bench for si_dac_multi: a 4-channel DUT checked against a channel model and an
// expected-output queue, plus a 3-channel DUT for out-of-range addressing.
module tb_si_dac_multi;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic soc = 1'b0, soc3 = 1'b0;
   logic SI = 1'b0, SI_en = 1'b0;
   logic ldac = 1'b0, ldac3 = 1'b0;
   real  a_out [4];
   real  a3_out [3];
   logic busy, done, frame_err;
   logic busy3, done3, err3;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [11:0] m_in [4];
   logic [11:0] m_dac [4];
   logic        m_pd [4];
   real         sb_q [$];

   si_dac_multi #(.WIDTH(12), .CH(4), .VREF(1.0)) dut (
      .clk(clk), .rst_n(rst_n), .soc(soc), .SI(SI), .SI_en(SI_en), .ldac(ldac),
      .A_out(a_out), .busy(busy), .done(done), .frame_err(frame_err)
   );

   si_dac_multi #(.WIDTH(12), .CH(3), .VREF(1.0)) dut3 (
      .clk(clk), .rst_n(rst_n), .soc(soc3), .SI(SI), .SI_en(SI_en), .ldac(ldac3),
      .A_out(a3_out), .busy(busy3), .done(done3), .frame_err(err3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic real model_a(int ch);
      return m_pd[ch] ? 0.0 : real'(m_dac[ch]) / 4096.0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_in[i] = '0; m_dac[i] = '0; m_pd[i] = 1'b0;
      end
   endfunction

   function automatic void model_frame(logic [1:0] cmd, logic [1:0] addr, logic [11:0] code);
      case (cmd)
         2'b00: m_in[addr] = code;
         2'b01: begin m_in[addr] = code; m_dac[addr] = code; m_pd[addr] = 1'b0; end
         2'b10: for (int i = 0; i < 4; i++) begin m_dac[i] = m_in[i]; m_pd[i] = 1'b0; end
         default: m_pd[addr] = 1'b1;
      endcase
   endfunction

   function automatic void model_ldac();
      for (int i = 0; i < 4; i++) begin m_dac[i] = m_in[i]; m_pd[i] = 1'b0; end
   endfunction

   function automatic void push_expect();
      for (int i = 0; i < 4; i++) sb_q.push_back(model_a(i));
   endfunction

   task automatic chk_bit(string tag, logic obs, logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic chk_int(string tag, int obs, int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic chk_real(string tag, real obs, real exp);
      n_checks++;
      assert ($realtobits(obs) === $realtobits(exp)) n_pass++;
      else $error("FAIL %s: observed=%f expected=%f", tag, obs, exp);
   endtask

   task automatic chk_sb(string tag);
      real e;
      chk_bit({tag, "_sb_depth"}, sb_q.size() >= 4, 1'b1);
      if (sb_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            e = sb_q.pop_front();
            chk_real($sformatf("%s_a%0d", tag, i), a_out[i], e);
         end
      end
   endtask

   // One soc cycle, then nbits MSB-first bits; stall inserts a disabled cycle (with inverted SI) before each bit.
   task automatic drive_frame(bit tgt, logic [1:0] cmd, logic [1:0] addr, logic [11:0] code,
                              int nbits, bit stall, output int soc_cyc);
      logic [15:0] f;
      f = {cmd, addr, code};
      @(negedge clk);
      if (tgt) soc3 = 1'b1; else soc = 1'b1;
      SI_en = 1'b0;
      @(negedge clk);
      soc = 1'b0; soc3 = 1'b0;
      soc_cyc = cyc;
      for (int b = 15; b > 15 - nbits; b--) begin
         if (stall) begin
            SI_en = 1'b0; SI = ~f[b];
            @(negedge clk);
         end
         SI_en = 1'b1; SI = f[b];
         @(negedge clk);
      end
      SI_en = 1'b0;
   endtask

   task automatic wait_done(bit tgt, int soc_cyc, output int lat);
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if ((tgt ? done3 : done) === 1'b1) begin
            lat = cyc - soc_cyc;
            break;
         end
      end
   endtask

   initial begin
      int sc, lat;
      model_reset();
      repeat (2) @(negedge clk);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk_bit("rst_err", frame_err, 1'b0);
      for (int i = 0; i < 4; i++) chk_real($sformatf("rst_a%0d", i), a_out[i], 0.0);
      rst_n = 1'b1;

      // Immediate update of channel 2 at mid-scale
      drive_frame(0, 2'b01, 2'd2, 12'h800, 16, 0, sc);
      model_frame(2'b01, 2'd2, 12'h800); push_expect();
      chk_bit("t1_busy_latch", busy, 1'b1);
      wait_done(0, sc, lat);
      chk_int("t1_latency", lat, 17);
      chk_bit("t1_busy_fall", busy, 1'b0);
      chk_sb("t1");
      chk_real("t1_a2_half", a_out[2], 0.5);
      @(negedge clk);
      chk_bit("t1_done_low", done, 1'b0);

      // Deferred writes then a global ldac
      drive_frame(0, 2'b00, 2'd0, 12'hFFF, 16, 0, sc);
      model_frame(2'b00, 2'd0, 12'hFFF); push_expect();
      wait_done(0, sc, lat);
      chk_sb("t2a");
      drive_frame(0, 2'b00, 2'd1, 12'h400, 16, 0, sc);
      model_frame(2'b00, 2'd1, 12'h400); push_expect();
      wait_done(0, sc, lat);
      chk_sb("t2b");
      @(negedge clk);
      ldac = 1'b1;
      chk_real("t2_pre_ldac_a0", a_out[0], 0.0);
      @(negedge clk);
      ldac = 1'b0;
      model_ldac();
      chk_real("t2_ldac_a0", a_out[0], 4095.0 / 4096.0);
      chk_real("t2_ldac_a1", a_out[1], 0.25);
      chk_real("t2_ldac_a2", a_out[2], 0.5);

      // Power-down and restore through cmd 10
      drive_frame(0, 2'b01, 2'd3, 12'h200, 16, 0, sc);
      model_frame(2'b01, 2'd3, 12'h200); push_expect();
      wait_done(0, sc, lat);
      chk_sb("t3a");
      chk_real("t3_a3_on", a_out[3], 0.125);
      drive_frame(0, 2'b11, 2'd3, 12'h555, 16, 0, sc);
      model_frame(2'b11, 2'd3, 12'h555); push_expect();
      wait_done(0, sc, lat);
      chk_sb("t3b");
      chk_real("t3_a3_pd", a_out[3], 0.0);
      drive_frame(0, 2'b10, 2'd3, 12'hABC, 16, 0, sc);
      model_frame(2'b10, 2'd3, 12'hABC); push_expect();
      wait_done(0, sc, lat);
      chk_sb("t3c");
      chk_real("t3_a3_restored", a_out[3], 0.125);

      // SI_en stalls before every bit
      drive_frame(0, 2'b01, 2'd1, 12'hC00, 16, 1, sc);
      model_frame(2'b01, 2'd1, 12'hC00); push_expect();
      wait_done(0, sc, lat);
      chk_int("t4_stall_latency", lat, 33);
      chk_sb("t4");
      chk_real("t4_a1", a_out[1], 0.75);

      // Abort after 7 bits; the restarted frame executes with the error still flagged
      drive_frame(0, 2'b01, 2'd0, 12'h123, 7, 0, sc);
      chk_bit("t5_err_before_abort", frame_err, 1'b0);
      drive_frame(0, 2'b00, 2'd0, 12'h0AA, 16, 0, sc);
      chk_bit("t5_err_set", frame_err, 1'b1);
      model_frame(2'b00, 2'd0, 12'h0AA); push_expect();
      wait_done(0, sc, lat);
      chk_int("t5_restart_latency", lat, 17);
      chk_sb("t5a");
      drive_frame(0, 2'b01, 2'd0, 12'h100, 16, 0, sc);
      chk_bit("t5_err_cleared", frame_err, 1'b0);
      model_frame(2'b01, 2'd0, 12'h100); push_expect();
      wait_done(0, sc, lat);
      chk_sb("t5b");
      chk_real("t5_a0", a_out[0], 0.0625);

      // 3-channel build: address 3 is out of range
      drive_frame(1, 2'b01, 2'd3, 12'h800, 16, 0, sc);
      wait_done(1, sc, lat);
      chk_int("t6_no_done", lat, -1);
      chk_bit("t6_err3", err3, 1'b1);
      chk_real("t6_a3_ch0", a3_out[0], 0.0);
      drive_frame(1, 2'b01, 2'd2, 12'h800, 16, 0, sc);
      chk_bit("t6_err3_cleared", err3, 1'b0);
      wait_done(1, sc, lat);
      chk_int("t6_latency", lat, 17);
      chk_real("t6_a3_ch2", a3_out[2], 0.5);

      // Asynchronous reset in the middle of a frame
      drive_frame(0, 2'b01, 2'd0, 12'hFFF, 8, 0, sc);
      chk_bit("t7_busy_mid", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_bit("t7_busy", busy, 1'b0);
      chk_bit("t7_done", done, 1'b0);
      chk_bit("t7_err", frame_err, 1'b0);
      for (int i = 0; i < 4; i++) chk_real($sformatf("t7_a%0d", i), a_out[i], model_a(i));
      chk_real("t7_a3_ch2", a3_out[2], 0.0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_bit("t7_idle_after", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
